conv_ctrl_regfile: RTL and testbench

Parametrised GPIO command decoder and control register file for the 2D-convolution datapath. It sits between the MicroBlaze GPIO bus and the convolution core, memory FSM and MCU readback path. It extends the single-kernel control block with these features:
- configurable data, length and readback widths
- N-entry indexed kernel loading
- an explicit LOAD/RUN/OUT state machine
- edge-qualified commands
- soft reset, status readback and a sticky illegal-command error flag

---
 rtl/conv_ctrl_regfile.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_ctrl_regfile.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_ctrl_regfile.sv
// conv_ctrl_regfile: GPIO command decoder and control register file for the
// 2D-convolution datapath. It decodes edge-qualified GPIO commands into kernel
// writes, the image length, FSM strobes and LOAD/RUN/OUT state control, and it
// returns either status or MCU result words on the GPIO readback.
//
// Ports:
//   i_CLK, i_rst        clock, synchronous active-high reset
//   i_gpio_data/op      command payload and opcode
//   i_gpio_valid        command strobe; only its 0->1 edge is acted on
//   i_mcu_data          result word from the result memory
//   i_eop               end of processing from the memory FSM
//   o_gpio_data         registered readback word (status or MCU data)
//   o_knl_data/idx      kernel word and its slot; o_knl_valid is the write pulse
//   o_img_len           image length register
//   o_fsm_valid         one-cycle data strobe to the FSM
//   o_load              one-cycle load-start pulse to the FSM
//   o_run, o_kn_or_img  high in RUN
//   o_eop_mcu           high in OUT
//   o_err               sticky illegal-command flag
//   o_state             0=LOAD 1=RUN 2=OUT
module conv_ctrl_regfile #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned IMG_LEN_W = 10,
    parameter int unsigned MCU_W     = 13,
    parameter int unsigned N_KNL     = 3,
    parameter int unsigned OP_W      = 3,
    parameter int unsigned KIDX_W    = (N_KNL > 1) ? $clog2(N_KNL) : 1
) (
    input  logic                 i_CLK,
    input  logic                 i_rst,
    input  logic [DATA_W-1:0]    i_gpio_data,
    input  logic [OP_W-1:0]      i_gpio_op,
    input  logic                 i_gpio_valid,
    input  logic [MCU_W-1:0]     i_mcu_data,
    input  logic                 i_eop,
    output logic [31:0]          o_gpio_data,
    output logic [DATA_W-1:0]    o_knl_data,
    output logic [KIDX_W-1:0]    o_knl_idx,
    output logic                 o_knl_valid,
    output logic [IMG_LEN_W-1:0] o_img_len,
    output logic                 o_fsm_valid,
    output logic                 o_load,
    output logic                 o_run,
    output logic                 o_eop_mcu,
    output logic                 o_kn_or_img,
    output logic                 o_err,
    output logic [1:0]           o_state
);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    localparam logic [OP_W-1:0] OP_KNL_LOAD  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SIZE_LOAD = OP_W'(1);
    localparam logic [OP_W-1:0] OP_IMG_LOAD  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DATA_REQ  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_GO_RUN    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_SOFT_RST  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_STATUS    = OP_W'(6);

    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(N_KNL - 1);

    logic [1:0]           r_state, w_state_nxt;
    logic [KIDX_W-1:0]    r_count, w_count_nxt;
    logic                 r_kfull, w_kfull_nxt;
    logic                 r_armed, w_armed_nxt;
    logic                 r_sel_status, w_sel_nxt;
    logic                 r_err, w_err_nxt;
    logic                 r_prev_valid;
    logic [IMG_LEN_W-1:0] r_img_len, w_img_len_nxt;
    logic [DATA_W-1:0]    r_knl_data, w_knl_data_nxt;
    logic [KIDX_W-1:0]    r_knl_idx, w_knl_idx_nxt;
    logic                 r_knl_valid, w_knl_valid_nxt;
    logic                 r_fsm_valid, w_fsm_valid_nxt;
    logic                 r_load, w_load_nxt;
    logic                 r_run, r_eop_mcu;
    logic [31:0]          r_gpio_data, w_gpio_nxt, w_status;
    logic                 w_edge, w_soft;

    assign w_edge   = i_gpio_valid & ~r_prev_valid;
    assign w_soft   = w_edge && (i_gpio_op == OP_SOFT_RST);
    // Status word reflects the register contents at the sampling edge
    assign w_status = {r_state, r_err, r_kfull, 8'(r_count), 20'b0};

    // Next-state and command decode
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_kfull_nxt     = r_kfull;
        w_armed_nxt     = r_armed;
        w_sel_nxt       = r_sel_status;
        w_err_nxt       = r_err;
        w_img_len_nxt   = r_img_len;
        w_knl_data_nxt  = r_knl_data;
        w_knl_idx_nxt   = r_knl_idx;
        w_knl_valid_nxt = 1'b0;
        w_fsm_valid_nxt = 1'b0;
        w_load_nxt      = 1'b0;

        // eop only matters in RUN; a same-cycle command is still judged as a RUN command
        if (r_state == ST_RUN && i_eop) begin
            w_state_nxt = ST_OUT;
        end

        if (w_edge) begin
            if (i_gpio_op == OP_STATUS) begin
                w_sel_nxt = 1'b1;
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        case (i_gpio_op)
                            OP_KNL_LOAD: begin
                                w_knl_data_nxt  = i_gpio_data;
                                w_knl_idx_nxt   = r_count;
                                w_knl_valid_nxt = 1'b1;
                                if (r_count == KIDX_LAST) begin
                                    w_count_nxt = '0;
                                    w_kfull_nxt = 1'b1;
                                end else begin
                                    w_count_nxt = r_count + KIDX_W'(1);
                                end
                            end
                            OP_SIZE_LOAD: w_img_len_nxt = i_gpio_data[IMG_LEN_W-1:0];
                            OP_IMG_LOAD: begin
                                w_fsm_valid_nxt = 1'b1;
                                w_load_nxt      = r_armed;
                                w_armed_nxt     = 1'b0;
                                w_sel_nxt       = 1'b0;
                            end
                            OP_DATA_REQ: begin
                                w_err_nxt = 1'b1;
                                w_sel_nxt = 1'b0;
                            end
                            OP_GO_RUN: begin
                                if (r_kfull && (r_img_len != '0)) begin
                                    w_state_nxt = ST_RUN;
                                end else begin
                                    w_err_nxt = 1'b1;
                                end
                            end
                            OP_SOFT_RST: ;
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                    ST_RUN: begin
                        if (i_gpio_op != OP_SOFT_RST) begin
                            w_err_nxt = 1'b1;
                        end
                    end
                    ST_OUT: begin
                        case (i_gpio_op)
                            OP_DATA_REQ: begin
                                w_fsm_valid_nxt = 1'b1;
                                w_sel_nxt       = 1'b0;
                            end
                            // Return to LOAD re-arms, and the re-armed load fires immediately
                            OP_IMG_LOAD: begin
                                w_state_nxt     = ST_LOAD;
                                w_fsm_valid_nxt = 1'b1;
                                w_load_nxt      = 1'b1;
                                w_armed_nxt     = 1'b0;
                                w_sel_nxt       = 1'b0;
                            end
                            OP_SOFT_RST: ;
                            default: w_err_nxt = 1'b1;
                        endcase
                    end
                    default: w_state_nxt = ST_LOAD;
                endcase
            end
        end

        w_gpio_nxt = w_sel_nxt ? w_status : 32'(i_mcu_data);
    end

    // Register stage; soft reset behaves as a full reset
    always_ff @(posedge i_CLK) begin
        r_prev_valid <= i_rst ? 1'b0 : i_gpio_valid;
        if (i_rst || w_soft) begin
            r_state      <= ST_LOAD;
            r_count      <= '0;
            r_kfull      <= 1'b0;
            r_armed      <= 1'b1;
            r_sel_status <= 1'b0;
            r_err        <= 1'b0;
            r_img_len    <= '0;
            r_knl_data   <= '0;
            r_knl_idx    <= '0;
            r_knl_valid  <= 1'b0;
            r_fsm_valid  <= 1'b0;
            r_load       <= 1'b0;
            r_run        <= 1'b0;
            r_eop_mcu    <= 1'b0;
            r_gpio_data  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_kfull      <= w_kfull_nxt;
            r_armed      <= w_armed_nxt;
            r_sel_status <= w_sel_nxt;
            r_err        <= w_err_nxt;
            r_img_len    <= w_img_len_nxt;
            r_knl_data   <= w_knl_data_nxt;
            r_knl_idx    <= w_knl_idx_nxt;
            r_knl_valid  <= w_knl_valid_nxt;
            r_fsm_valid  <= w_fsm_valid_nxt;
            r_load       <= w_load_nxt;
            r_run        <= (w_state_nxt == ST_RUN);
            r_eop_mcu    <= (w_state_nxt == ST_OUT);
            r_gpio_data  <= w_gpio_nxt;
        end
    end

    assign o_gpio_data = r_gpio_data;
    assign o_knl_data  = r_knl_data;
    assign o_knl_idx   = r_knl_idx;
    assign o_knl_valid = r_knl_valid;
    assign o_img_len   = r_img_len;
    assign o_fsm_valid = r_fsm_valid;
    assign o_load      = r_load;
    assign o_run       = r_run;
    assign o_kn_or_img = r_run;
    assign o_eop_mcu   = r_eop_mcu;
    assign o_err       = r_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_conv_ctrl_regfile.sv
// tb_conv_ctrl_regfile: directed test-plan steps followed by random commands,
// every cycle compared against a behavioural model of the command rules.
module tb_conv_ctrl_regfile;

    localparam int N = 3;
    localparam logic [2:0] KNL = 3'd0, SIZE = 3'd1, IMG = 3'd2, DREQ = 3'd3,
                           GO = 3'd4, SRST = 3'd5, STAT = 3'd6, RSV = 3'd7;

    logic        i_CLK = 1'b0;
    logic        i_rst = 1'b0;
    logic [23:0] i_gpio_data = '0;
    logic [2:0]  i_gpio_op = '0;
    logic        i_gpio_valid = 1'b0;
    logic [12:0] i_mcu_data = '0;
    logic        i_eop = 1'b0;
    logic [31:0] o_gpio_data;
    logic [23:0] o_knl_data;
    logic [1:0]  o_knl_idx;
    logic        o_knl_valid;
    logic [9:0]  o_img_len;
    logic        o_fsm_valid, o_load, o_run, o_eop_mcu, o_kn_or_img, o_err;
    logic [1:0]  o_state;

    conv_ctrl_regfile dut (
        .i_CLK(i_CLK), .i_rst(i_rst), .i_gpio_data(i_gpio_data),
        .i_gpio_op(i_gpio_op), .i_gpio_valid(i_gpio_valid),
        .i_mcu_data(i_mcu_data), .i_eop(i_eop), .o_gpio_data(o_gpio_data),
        .o_knl_data(o_knl_data), .o_knl_idx(o_knl_idx), .o_knl_valid(o_knl_valid),
        .o_img_len(o_img_len), .o_fsm_valid(o_fsm_valid), .o_load(o_load),
        .o_run(o_run), .o_eop_mcu(o_eop_mcu), .o_kn_or_img(o_kn_or_img),
        .o_err(o_err), .o_state(o_state)
    );

    always #5 i_CLK = ~i_CLK;

    int total = 0;
    int bad = 0;

    // Model of the visible register state (state: 0 LOAD, 1 RUN, 2 OUT)
    int          m_state = 0, m_count = 0, m_len = 0, m_kidx = 0;
    bit          m_full = 0, m_armed = 1, m_prev = 0, m_sel = 0, m_err = 0;
    bit          m_kvalid = 0, m_fvalid = 0, m_load = 0;
    logic [23:0] m_kdata = '0;
    logic [31:0] m_gpio = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit v, input logic [2:0] op, input logic [23:0] d,
                              input bit eop, input logic [12:0] mcu, input bit rst);
        bit e;
        int ns;
        logic [31:0] st;
        e = v && !m_prev;
        m_kvalid = 0; m_fvalid = 0; m_load = 0;
        if (rst || (e && op == SRST)) begin
            m_state = 0; m_count = 0; m_len = 0; m_kidx = 0; m_full = 0;
            m_armed = 1; m_sel = 0; m_err = 0; m_kdata = '0; m_gpio = '0;
            m_prev = rst ? 1'b0 : v;
            return;
        end
        st = (32'(m_state) << 30) | (32'(m_err) << 29) | (32'(m_full) << 28) | (32'(m_count) << 20);
        ns = m_state;
        if (m_state == 1 && eop) ns = 2;
        if (e) begin
            if (op == STAT) m_sel = 1;
            else if (m_state == 0) begin
                case (op)
                    KNL: begin
                        m_kdata = d; m_kidx = m_count; m_kvalid = 1;
                        if (m_count == N - 1) m_full = 1;
                        m_count = (m_count + 1) % N;
                    end
                    SIZE: m_len = int'(d) % 1024;
                    IMG: begin m_fvalid = 1; m_load = m_armed; m_armed = 0; m_sel = 0; end
                    DREQ: begin m_err = 1; m_sel = 0; end
                    GO: if (m_full && m_len != 0) ns = 1; else m_err = 1;
                    default: m_err = 1;
                endcase
            end else if (m_state == 1) m_err = 1;
            else begin
                case (op)
                    DREQ: begin m_fvalid = 1; m_sel = 0; end
                    IMG: begin ns = 0; m_fvalid = 1; m_load = 1; m_armed = 0; m_sel = 0; end
                    default: m_err = 1;
                endcase
            end
        end
        m_gpio = m_sel ? st : 32'(mcu);
        m_state = ns;
        m_prev = v;
    endtask

    task automatic check_all();
        chk("gpio_data", o_gpio_data, m_gpio);
        chk("knl_data", 32'(o_knl_data), 32'(m_kdata));
        chk("knl_idx", 32'(o_knl_idx), 32'(m_kidx));
        chk("knl_valid", 32'(o_knl_valid), 32'(m_kvalid));
        chk("img_len", 32'(o_img_len), 32'(m_len));
        chk("fsm_valid", 32'(o_fsm_valid), 32'(m_fvalid));
        chk("load", 32'(o_load), 32'(m_load));
        chk("run", 32'(o_run), 32'(m_state == 1));
        chk("kn_or_img", 32'(o_kn_or_img), 32'(m_state == 1));
        chk("eop_mcu", 32'(o_eop_mcu), 32'(m_state == 2));
        chk("err", 32'(o_err), 32'(m_err));
        chk("state", 32'(o_state), 32'(m_state));
    endtask

    task automatic tick(input bit v, input logic [2:0] op, input logic [23:0] d,
                        input bit eop, input logic [12:0] mcu, input bit rst);
        i_gpio_valid = v; i_gpio_op = op; i_gpio_data = d;
        i_eop = eop; i_mcu_data = mcu; i_rst = rst;
        @(posedge i_CLK);
        model_step(v, op, d, eop, mcu, rst);
        #1;
        check_all();
    endtask

    task automatic send(input logic [2:0] op, input logic [23:0] d);
        tick(1'b1, op, d, 1'b0, 13'h1ABC, 1'b0);
    endtask

    task automatic idle();
        tick(1'b0, RSV, 24'h0, 1'b0, 13'h1ABC, 1'b0);
    endtask

    initial begin
        // Reset
        tick(1'b0, RSV, 24'h0, 1'b0, 13'h0, 1'b1);
        tick(1'b0, RSV, 24'h0, 1'b0, 13'h0, 1'b1);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_gpio", o_gpio_data, 32'd0);

        // Three kernel loads; the third strobe is held high for five cycles
        send(KNL, 24'h000111); chk("k0_idx", 32'(o_knl_idx), 0); chk("k0_data", 32'(o_knl_data), 32'h111); idle();
        send(KNL, 24'h000222); chk("k1_idx", 32'(o_knl_idx), 1); chk("k1_data", 32'(o_knl_data), 32'h222); idle();
        send(KNL, 24'h000333); chk("k2_idx", 32'(o_knl_idx), 2); chk("k2_vld", 32'(o_knl_valid), 1);
        for (int i = 0; i < 4; i++) begin
            send(KNL, 24'h000333);
            chk("hold_vld", 32'(o_knl_valid), 0);
        end
        idle();

        // Size, two image loads, run
        send(SIZE, 24'h0003FF); chk("len", 32'(o_img_len), 1023); idle();
        send(IMG, 24'h0); chk("load1", 32'(o_load), 1); chk("fv1", 32'(o_fsm_valid), 1); idle();
        send(IMG, 24'h0); chk("load2", 32'(o_load), 0); chk("fv2", 32'(o_fsm_valid), 1); idle();
        send(GO, 24'h0); chk("go_state", 32'(o_state), 1); chk("go_run", 32'(o_run), 1); idle();

        // eop together with DATA_REQ in RUN, then DATA_REQ in OUT
        tick(1'b1, DREQ, 24'h0, 1'b1, 13'h1ABC, 1'b0);
        chk("eop_state", 32'(o_state), 2); chk("eop_mcu", 32'(o_eop_mcu), 1); chk("eop_err", 32'(o_err), 1);
        idle();
        send(DREQ, 24'h0); chk("out_fv", 32'(o_fsm_valid), 1); chk("out_gpio", o_gpio_data, 32'h00001ABC); idle();

        // Back to LOAD, kernels retained so GO_RUN is immediately legal
        send(IMG, 24'h0); chk("ret_state", 32'(o_state), 0); chk("ret_load", 32'(o_load), 1); idle();
        send(GO, 24'h0); chk("rego_state", 32'(o_state), 1); idle();

        // Hard reset mid-RUN
        tick(1'b0, RSV, 24'h0, 1'b0, 13'h1ABC, 1'b1);
        chk("mrst_err", 32'(o_err), 0); chk("mrst_run", 32'(o_run), 0);

        // GO_RUN with only two kernels, then STATUS readback
        send(KNL, 24'h00000A); idle();
        send(KNL, 24'h00000B); idle();
        send(SIZE, 24'h000005); idle();
        send(GO, 24'h0); chk("go2_err", 32'(o_err), 1); chk("go2_state", 32'(o_state), 0); idle();
        send(STAT, 24'h0); chk("status", o_gpio_data, 32'h20200000); idle();

        // Soft reset, full kernel set, GO_RUN with zero length
        send(SRST, 24'h0); chk("srst_err", 32'(o_err), 0); idle();
        for (int i = 0; i < N; i++) begin send(KNL, 24'(i + 5)); idle(); end
        send(GO, 24'h0); chk("golen0_err", 32'(o_err), 1); chk("golen0_state", 32'(o_state), 0); idle();

        // Reach OUT, soft reset there, then first IMG_LOAD pulses o_load again
        send(SIZE, 24'h000010); idle();
        send(GO, 24'h0); idle();
        tick(1'b0, RSV, 24'h0, 1'b1, 13'h0555, 1'b0);
        chk("out2_state", 32'(o_state), 2);
        send(SRST, 24'h0);
        chk("srst_out_state", 32'(o_state), 0); chk("srst_out_len", 32'(o_img_len), 0);
        chk("srst_out_gpio", o_gpio_data, 0); chk("srst_out_eop", 32'(o_eop_mcu), 0);
        idle();
        send(IMG, 24'h0); chk("rearm_load", 32'(o_load), 1); idle();

        // Random commands against the model
        for (int i = 0; i < 1500; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op == SRST && $urandom_range(0, 3) != 0) op = GO;
            tick(1'($urandom_range(0, 1)), op, 24'($urandom), $urandom_range(0, 5) == 0,
                 13'($urandom), $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
